// File: rtl/sum_lt_sched_if.sv
// Request/response bundle for the shared sum-vs-threshold compare scheduler.
// master = requester/consumer side, slave = scheduler side.
interface sum_lt_sched_if #(
  parameter int NREQ = 4,
  parameter int A_W  = 3,
  parameter int B_W  = 4,
  parameter int T_W  = 9
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*A_W-1:0] req_a;
  logic [NREQ*B_W-1:0] req_b;
  logic [NREQ*T_W-1:0] req_thr;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic                rsp_lt;

  modport master (
    output req_valid, req_a, req_b, req_thr, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_lt
  );

  modport slave (
    input  req_valid, req_a, req_b, req_thr, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_lt
  );
endinterface

// File: rtl/sum_lt_sched.sv
// Round-robin scheduler sharing one (a + b) < thr compare unit among NREQ requesters.
// Optional SUM_LT_SCHED_B2B_EN: re-arbitrate in the response-accept cycle (2 cycles per transaction).
//
// state | meaning
// IDLE  | waiting for any req_valid; grant and capture operands
// CALC  | evaluate compare on registered operands
// RESP  | hold result until rsp_ready
module sum_lt_sched #(
  parameter int NREQ = 4,
  parameter int A_W  = 3,
  parameter int B_W  = 4,
  parameter int T_W  = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  sum_lt_sched_if.slave  bus
);
  localparam int ID_W = $clog2(NREQ);
  localparam int S_W  = ((A_W > B_W) ? A_W : B_W) + 1;
  localparam int C_W  = (S_W > T_W) ? S_W : T_W;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [A_W-1:0]  op_a;
  logic [B_W-1:0]  op_b;
  logic [T_W-1:0]  op_thr;
  logic [ID_W-1:0] op_id;
  logic            rsp_valid_q;
  logic [ID_W-1:0] rsp_id_q;
  logic            rsp_lt_q;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] cand;
  logic            arb_en;
  logic            grant;
  logic [A_W-1:0]  sel_a;
  logic [B_W-1:0]  sel_b;
  logic [T_W-1:0]  sel_thr;
  logic            lt_calc;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NREQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

`ifdef SUM_LT_SCHED_B2B_EN
  assign arb_en = (state == IDLE) || ((state == RESP) && bus.rsp_ready);
`else
  assign arb_en = (state == IDLE);
`endif

  assign grant = arb_en && gnt_found;

  always_comb begin
    bus.req_ready = '0;
    sel_a         = '0;
    sel_b         = '0;
    sel_thr       = '0;
    if (rst_n && grant) bus.req_ready[gnt_idx] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_a   = bus.req_a[i*A_W +: A_W];
        sel_b   = bus.req_b[i*B_W +: B_W];
        sel_thr = bus.req_thr[i*T_W +: T_W];
      end
    end
  end

  // Zero-extended to a common width so the sum can never wrap.
  assign lt_calc = (C_W'(op_a) + C_W'(op_b)) < C_W'(op_thr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = grant ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_thr      <= '0;
      op_id       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_lt_q    <= 1'b0;
    end else begin
      if (grant) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        op_thr <= sel_thr;
        op_id  <= gnt_idx;
        rr_ptr <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (state == CALC) begin
        rsp_lt_q    <= lt_calc;
        rsp_id_q    <= op_id;
        rsp_valid_q <= 1'b1;
      end else if ((state == RESP) && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_lt    = rsp_lt_q;
endmodule

// File: tb/tb_sum_lt_sched.sv
// Self-checking bench for sum_lt_sched: directed corner cases plus randomized
// traffic compared against a round-robin / arithmetic reference model.
module tb_sum_lt_sched;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   ma[4], mb[4], mt[4];

`ifdef SUM_LT_SCHED_B2B_EN
  localparam int SPACING = 2;
`else
  localparam int SPACING = 3;
`endif

  sum_lt_sched_if #(.NREQ(4), .A_W(3), .B_W(4), .T_W(9)) bus ();
  sum_lt_sched #(.NREQ(4), .A_W(3), .B_W(4), .T_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit ref_lt(input int a, input int b, input int t);
    return (a + b) < t;
  endfunction

  function automatic int pick(input int mask, input int ptr);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (ptr + k) % 4;
      if (mask[j]) return j;
    end
    return -1;
  endfunction

  task automatic set_req(input int r, input int a, input int b, input int t);
    ma[r] = a; mb[r] = b; mt[r] = t;
    bus.req_a[r*3 +: 3]   = 3'(a);
    bus.req_b[r*4 +: 4]   = 4'(b);
    bus.req_thr[r*9 +: 9] = 9'(t);
  endtask

  task automatic rand_req(input int r);
    set_req(r, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 511));
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b0;
    for (int r = 0; r < 4; r++) rand_req(r);
    @(negedge clk); @(negedge clk); #1;
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_id !== 2'd0) begin n_errors++; $display("FAIL reset_rsp_id got=%0d exp=0", bus.rsp_id); end
    n_checks++; if (bus.rsp_lt !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_lt got=%b exp=0", bus.rsp_lt); end
    n_checks++; if (bus.req_ready !== 4'h0) begin n_errors++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'h0;
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 4'h0) begin n_errors++; $display("FAIL idle_no_valid_ready got=%b exp=0000", bus.req_ready); end
  endtask

  task automatic test_operands;
    int tr[6] = '{0, 0, 2, 2, 2, 2};
    int ta[6] = '{3, 3, 7, 7, 0, 7};
    int tb[6] = '{5, 5, 15, 15, 0, 15};
    int tt[6] = '{9, 8, 22, 23, 0, 511};
    int r, a, b, t;
    bit exp_lt;
    for (int n = 0; n < 16; n++) begin
      if (n < 6) begin r = tr[n]; a = ta[n]; b = tb[n]; t = tt[n]; end
      else begin r = $urandom_range(0, 3); a = $urandom_range(0, 7); b = $urandom_range(0, 15); t = $urandom_range(0, 40); end
      exp_lt = ref_lt(a, b, t);
      @(negedge clk);
      set_req(r, a, b, t);
      bus.req_valid = 4'(1 << r);
      #1;
      n_checks++; if (bus.req_ready !== 4'(1 << r)) begin n_errors++; $display("FAIL op%0d_grant got=%b exp=%b", n, bus.req_ready, 4'(1 << r)); end
      @(negedge clk);
      bus.req_valid = 4'h0;
      bus.rsp_ready = 1'($urandom_range(0, 1));
      #1;
      n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'h0) begin n_errors++; $display("FAIL op%0d_calc rsp_valid=%b req_ready=%b exp 0/0000", n, bus.rsp_valid, bus.req_ready); end
      @(negedge clk); #1;
      n_checks++; if (bus.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL op%0d_latency rsp_valid got=%b exp=1", n, bus.rsp_valid); end
      n_checks++; if (bus.rsp_id !== 2'(r)) begin n_errors++; $display("FAIL op%0d_id got=%0d exp=%0d", n, bus.rsp_id, r); end
      n_checks++; if (bus.rsp_lt !== exp_lt) begin n_errors++; $display("FAIL op%0d_lt a=%0d b=%0d thr=%0d got=%b exp=%b", n, a, b, t, bus.rsp_lt, exp_lt); end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      #1;
      n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL op%0d_release rsp_valid got=%b exp=0", n, bus.rsp_valid); end
    end
  endtask

  task automatic test_hold;
    bit exp_lt;
    @(negedge clk);
    rand_req(1);
    exp_lt = ref_lt(ma[1], mb[1], mt[1]);
    bus.req_valid = 4'b0010;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_errors++; $display("FAIL hold_grant got=%b exp=0010", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'h0;
    @(negedge clk);
    bus.req_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_lt !== exp_lt || bus.req_ready !== 4'h0) begin
        n_errors++;
        $display("FAIL hold_c%0d valid=%b id=%0d lt=%b ready=%b exp 1/1/%b/0000", c, bus.rsp_valid, bus.rsp_id, bus.rsp_lt, bus.req_ready, exp_lt);
      end
      @(negedge clk);
    end
    bus.req_valid = 4'h0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL hold_release rsp_valid got=%b exp=0", bus.rsp_valid); end
  endtask

  task automatic test_reset_mid;
    bit exp_lt;
    @(negedge clk);
    rand_req(2);
    bus.req_valid = 4'b0100;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0100) begin n_errors++; $display("FAIL rmid_grant2 got=%b exp=0100", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'h0;
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'h0) begin n_errors++; $display("FAIL rmid_in_reset valid=%b ready=%b exp 0/0000", bus.rsp_valid, bus.req_ready); end
    @(negedge clk);
    rand_req(1); rand_req(3);
    exp_lt = ref_lt(ma[1], mb[1], mt[1]);
    bus.req_valid = 4'b1010;
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_dropped rsp_valid got=%b exp=0", bus.rsp_valid); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 4'(1 << pick(4'b1010, 0))) begin n_errors++; $display("FAIL rmid_ptr_reset got=%b exp=%b", bus.req_ready, 4'(1 << pick(4'b1010, 0))); end
    @(negedge clk);
    bus.req_valid = 4'h0;
    #1;
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_calc rsp_valid got=%b exp=0", bus.rsp_valid); end
    @(negedge clk); #1;
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_lt !== exp_lt) begin n_errors++; $display("FAIL rmid_rsp valid=%b id=%0d lt=%b exp 1/1/%b", bus.rsp_valid, bus.rsp_id, bus.rsp_lt, exp_lt); end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  // Continuous traffic from reset with rsp_ready tied high.
  task automatic test_stream(input string nm, input int mask, input int ncyc);
    int ptr = 0, ngr = 0, nrsp = 0, last_gnt = -1, pend = -1, g;
    int qid[$];
    bit qlt[$];
    int eid;
    bit elt;
    @(negedge clk);
    rst_n = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int r = 0; r < 4; r++) rand_req(r);
    bus.req_valid = 4'(mask);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      if (pend >= 0) begin rand_req(pend); pend = -1; end
      #1;
      if (bus.rsp_valid === 1'b1) begin
        nrsp++;
        n_checks++;
        if (qid.size() == 0) begin
          n_errors++; $display("FAIL %s_unexpected_rsp c=%0d id=%0d", nm, c, bus.rsp_id);
        end else begin
          eid = qid.pop_front(); elt = qlt.pop_front();
          if (bus.rsp_id !== 2'(eid)) begin n_errors++; $display("FAIL %s_rsp_id c=%0d got=%0d exp=%0d", nm, c, bus.rsp_id, eid); end
          n_checks++;
          if (bus.rsp_lt !== elt) begin n_errors++; $display("FAIL %s_rsp_lt c=%0d got=%b exp=%b", nm, c, bus.rsp_lt, elt); end
        end
      end
      if (bus.req_ready !== 4'h0) begin
        g = pick(mask, ptr);
        n_checks++;
        if (bus.req_ready !== 4'(1 << g)) begin n_errors++; $display("FAIL %s_grant c=%0d got=%b exp=%b", nm, c, bus.req_ready, 4'(1 << g)); end
        qid.push_back(g);
        qlt.push_back(ref_lt(ma[g], mb[g], mt[g]));
        if (last_gnt >= 0) begin
          n_checks++;
          if (c - last_gnt != SPACING) begin n_errors++; $display("FAIL %s_spacing c=%0d got=%0d exp=%0d", nm, c, c - last_gnt, SPACING); end
        end
        last_gnt = c;
        ptr = (g + 1) % 4;
        pend = g;
        ngr++;
      end
      @(negedge clk);
    end
    n_checks++; if (ngr < ncyc / SPACING - 1) begin n_errors++; $display("FAIL %s_grant_count got=%0d exp>=%0d", nm, ngr, ncyc / SPACING - 1); end
    n_checks++; if (nrsp < ngr - 1) begin n_errors++; $display("FAIL %s_rsp_count got=%0d exp>=%0d", nm, nrsp, ngr - 1); end
    bus.req_valid = 4'h0;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    bus.req_valid = 4'h0;
    bus.rsp_ready = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_thr   = '0;
    test_reset;
    test_operands;
    test_hold;
    test_reset_mid;
    test_stream("round_robin", 4'b1111, 40);
    test_stream("throughput", 4'b1010, 30);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
